// File: rtl/soc_msp430_dbg_i2c_master.sv
// Debug I2C master: byte-command engine behind a 16-byte MSP430 peripheral window.
// Optional feature: define DBG_I2C_MASTER_IRQ_EN to enable irq_i2c = DONE & IE.
module soc_msp430_dbg_i2c_master #(
  parameter logic [14:0] BASE_ADDR    = 15'h0090,
  parameter logic [15:0] PRESCALE_RST = 16'd49
)(
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        i2c_scl_out,
  output logic        i2c_sda_out,
  input  logic        i2c_sda_in,
  output logic        irq_i2c
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  localparam logic [2:0] R_CTRL = 3'd0, R_TX = 3'd1, R_RX = 3'd2, R_STAT = 3'd3, R_PRE = 3'd4;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, hcnt_q, hcnt_d, pre_q, pre_d;
  logic        ph_q, ph_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d, tx_q, tx_d, rx_q, rx_d;
  logic        start_q, start_d, stop_q, stop_d, rd_q, rd_d, nrd_q, nrd_d, ie_q, ie_d;
  logic        busy_q, busy_d, done_q, done_d, nack_q, nack_d;
  logic        hscl_q, hscl_d, hsda_q, hsda_d;
  logic        scl_c, sda_c, tick, fin, go, sel, wr, wr_idle;
  logic [2:0]  reg_w;

  // 16-byte window = 8 words; only full-word writes are accepted
  assign sel     = per_en && (per_addr[13:3] == BASE_ADDR[14:4]);
  assign reg_w   = per_addr[2:0];
  assign wr      = sel && (per_we == 2'b11);
  assign wr_idle = wr && !busy_q;
  assign go      = wr_idle && (reg_w == R_CTRL) && per_din[4];
  assign tick    = (cnt_q == hcnt_q);

  // State register; reset releases both lines at once since the line mux follows state_q
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE; cnt_q <= '0; hcnt_q <= '0; pre_q <= PRESCALE_RST;
      ph_q <= 1'b0; bit_q <= '0; sh_q <= '0; tx_q <= '0; rx_q <= '0;
      start_q <= 1'b0; stop_q <= 1'b0; rd_q <= 1'b0; nrd_q <= 1'b0; ie_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; nack_q <= 1'b0; hscl_q <= 1'b1; hsda_q <= 1'b1;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; hcnt_q <= hcnt_d; pre_q <= pre_d;
      ph_q <= ph_d; bit_q <= bit_d; sh_q <= sh_d; tx_q <= tx_d; rx_q <= rx_d;
      start_q <= start_d; stop_q <= stop_d; rd_q <= rd_d; nrd_q <= nrd_d; ie_q <= ie_d;
      busy_q <= busy_d; done_q <= done_d; nack_q <= nack_d; hscl_q <= hscl_d; hsda_q <= hsda_d;
    end
  end

  // Next-state and register-file update; every state is two H-long phases (ph_q)
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; hcnt_d = hcnt_q; pre_d = pre_q;
    ph_d = ph_q; bit_d = bit_q; sh_d = sh_q; tx_d = tx_q; rx_d = rx_q;
    start_d = start_q; stop_d = stop_q; rd_d = rd_q; nrd_d = nrd_q; ie_d = ie_q;
    busy_d = busy_q; done_d = done_q; nack_d = nack_q; hscl_d = hscl_q; hsda_d = hsda_q;
    fin = 1'b0;
    // CTRL/TXDATA/PRESCALE are frozen while a command runs
    if (wr_idle && reg_w == R_CTRL) begin
      start_d = per_din[0]; stop_d = per_din[1]; rd_d = per_din[2]; nrd_d = per_din[3];
`ifdef DBG_I2C_MASTER_IRQ_EN
      ie_d = per_din[5];
`else
      ie_d = 1'b0;
`endif
    end
    if (wr_idle && reg_w == R_TX)  tx_d  = per_din[7:0];
    if (wr_idle && reg_w == R_PRE) pre_d = per_din;
    if (wr && reg_w == R_STAT) begin
      if (per_din[1]) done_d = 1'b0;
      if (per_din[2]) nack_d = 1'b0;
    end
    case (state_q)
      S_IDLE: if (go) begin
        state_d = per_din[0] ? S_START : S_BIT;
        cnt_d = '0; ph_d = 1'b0; bit_d = 3'd7; hcnt_d = pre_q; busy_d = 1'b1;
      end
      default: if (!tick) cnt_d = cnt_q + 16'd1;
      else begin
        cnt_d = '0;
        ph_d  = ~ph_q;
        if (ph_q) begin
          case (state_q)
            S_START: state_d = S_BIT;
            S_BIT: begin
              sh_d = {sh_q[6:0], i2c_sda_in};
              if (bit_q == 3'd0) begin
                state_d = S_ACK;
                if (rd_q) rx_d = {sh_q[6:0], i2c_sda_in};
              end else bit_d = bit_q - 3'd1;
            end
            S_ACK: begin
              if (!rd_q && i2c_sda_in) nack_d = 1'b1;
              if (stop_q) state_d = S_STOP;
              else fin = 1'b1;
            end
            S_STOP: fin = 1'b1;
            default: ;
          endcase
        end
      end
    endcase
    // STOP ends as SDA is released; the idle bus then provides the free time.
    // Without STOP, SCL parks low and SDA keeps its last value.
    if (fin) begin
      state_d = S_IDLE; busy_d = 1'b0; done_d = 1'b1;
      hscl_d  = stop_q;
      hsda_d  = stop_q ? 1'b1 : sda_c;
    end
  end

  // Line drive per state; IDLE replays the held levels
  always_comb begin
    scl_c = hscl_q;
    sda_c = hsda_q;
    case (state_q)
      S_START: begin scl_c = 1'b1;  sda_c = ~ph_q; end
      S_BIT:   begin scl_c = ph_q;  sda_c = rd_q ? 1'b1 : tx_q[bit_q]; end
      S_ACK:   begin scl_c = ph_q;  sda_c = rd_q ? nrd_q : 1'b1; end
      S_STOP:  begin scl_c = ph_q;  sda_c = 1'b0; end
      default: ;
    endcase
  end

  assign i2c_scl_out = scl_c;
  assign i2c_sda_out = sda_c;
  assign irq_i2c     = done_q & ie_q;

  // Combinational register read, zero when unselected or in reset
  always_comb begin
    per_dout = 16'h0000;
    if (sel && reset_n) begin
      case (reg_w)
        R_CTRL:  per_dout = {10'd0, ie_q, 1'b0, nrd_q, rd_q, stop_q, start_q};
        R_TX:    per_dout = {8'd0, tx_q};
        R_RX:    per_dout = {8'd0, rx_q};
        R_STAT:  per_dout = {13'd0, nack_q, done_q, busy_q};
        R_PRE:   per_dout = pre_q;
        default: per_dout = 16'h0000;
      endcase
    end
  end

endmodule
